hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller for the 5-stage MIPS core. It drives the write enables, flush and bubble controls of the PC, IF/ID and ID/EX pipeline registers. It resolves load-use hazards with a configurable stall length, flushes IF/ID on taken branches, and freezes the front end while data memory is busy. It also keeps saturating event counters for performance debug.

## Interface
- `STALL_CYCLES`, default 1: load-use stall length in cycles. Legal values are 1 (MEM→EX forwarding present) and 2 (no forwarding).
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `idex_memread`  in  1  MemRead currently held in ID/EX.
- `idex_rt_addr`  in  5  Rt address currently held in ID/EX (load destination).
- `ifid_rs_addr`  in  5  Rs field of the instruction in ID.
- `ifid_rt_addr`  in  5  Rt field of the instruction in ID.
- `ifid_uses_rt`  in  1  the instruction in ID reads Rt as a source.
- `branch_taken`  in  1  branch in ID resolved taken this cycle.
- `mem_busy`  in  1  data memory not ready; the pipeline must hold.
- `clr_stats`  in  1  synchronous clear of all counters.
- `pc_write`  out  1  PC load enable.
- `ifid_write`  out  1  IF/ID load enable.
- `ifid_flush`  out  1  load a NOP into IF/ID.
- `idex_write`  out  1  ID/EX load enable.
- `idex_bubble`  out  1  force zero control signals (RegWrite, MemtoReg, MemRead, MemWrite, ALUSrc, ALUOp, RegDst) into ID/EX.
- `stalling`  out  1  high in every load-use stall cycle.
- `stall_cnt`  out  16  load-use stall cycles, saturating.
- `flush_cnt`  out  16  IF/ID flushes, saturating.
- `freeze_cnt`  out  16  freeze cycles, saturating.

## Operation
- Hazard condition `hz` = `idex_memread` & (`idex_rt_addr` != 0) & ((`idex_rt_addr` == `ifid_rs_addr`) | (`ifid_uses_rt` & `idex_rt_addr` == `ifid_rt_addr`)).
- FSM states are RUN, STALL and FREEZE. The FSM also holds a 1-bit stall counter `cnt`, a saved state `ret` and a saved counter `ret_cnt`.
- The control outputs are Mealy functions of state and inputs. Priority is freeze, then load-use, then branch.
- **Freeze, any state, `mem_busy`=1:**
  - `pc_write`, `ifid_write`, `idex_write`, `ifid_flush`, `idex_bubble` and `stalling` are all 0.
  - `ret` takes the current state and `ret_cnt` takes `cnt`, but only on entry from RUN or STALL.
  - Next state is FREEZE.
- **RUN, `hz`=1:**
  - `pc_write`=0, `ifid_write`=0, `idex_write`=1, `idex_bubble`=1, `stalling`=1.
  - If STALL_CYCLES=2, next state is STALL with `cnt`=1.
  - If STALL_CYCLES=1, the state stays RUN.
  - A simultaneous `branch_taken` is ignored this cycle. The branch is held in ID and re-resolves after the stall.
- **RUN, `hz`=0, `branch_taken`=1:** all write enables are 1 and `ifid_flush`=1.
- **RUN, idle:** all write enables are 1; flush and bubble are 0.
- **STALL:**
  - Outputs are the same as the RUN/`hz` case, independent of `hz` and `branch_taken`.
  - `cnt` decrements; when `cnt`=1, next state is RUN.
- **FREEZE, `mem_busy`=0:**
  - Outputs are evaluated as in state `ret`.
  - Next state is derived from `ret`/`ret_cnt`, exactly as if the freeze cycles had not occurred.
- **Counters:**
  - `stall_cnt` increments on every cycle with `stalling`=1.
  - `flush_cnt` increments on every cycle with `ifid_flush`=1.
  - `freeze_cnt` increments on every cycle with `mem_busy`=1.
  - All three saturate at 16'hFFFF.
  - `clr_stats` zeroes all counters and wins over increments in the same cycle.

## Timing
- Reset (`rst`=1 sampled at an edge):
  - State becomes RUN; `cnt`, `ret` and `ret_cnt` are cleared; all counters become 0.
  - While `rst` is high, the outputs are `pc_write`=0, `ifid_write`=0, `idex_write`=0, `ifid_flush`=0, `idex_bubble`=1, `stalling`=0.
- Reset in STALL or FREEZE aborts the operation. The first cycle after `rst` falls is RUN with no residual stall.
- Control outputs have zero latency, so the pipeline registers use them at the same edge. Counters update one edge after the qualifying cycle.
- Load-use stall length is exactly STALL_CYCLES non-frozen cycles, regardless of freezes inserted mid-stall.
- `ifid_flush` is asserted for exactly 1 cycle per taken branch resolved in RUN without a hazard.
- `mem_busy` held for N cycles gives exactly N frozen cycles and adds N to `freeze_cnt`.

## Test plan
- **STALL_CYCLES=1, hazard on Rs:** load with Rt=5, then a consumer with Rs=5.
  - One cycle with `pc_write`=0, `ifid_write`=0, `idex_bubble`=1.
  - Next cycle all enables are 1; `stall_cnt`=1.
- **STALL_CYCLES=2, hazard on Rt:** `idex_rt_addr`=7, `ifid_rt_addr`=7, `ifid_uses_rt`=1.
  - Exactly 2 stall cycles.
  - `ifid_uses_rt`=0 with the same addresses gives 0 stall cycles.
  - `idex_rt_addr`=0 gives no stall.
- **Hazard and branch together:** `hz`=1 and `branch_taken`=1 in the same cycle.
  - No flush during the stall.
  - On the first RUN cycle with `branch_taken` held, `ifid_flush`=1 for 1 cycle; `flush_cnt`=1.
- **Freeze mid-stall (STALL_CYCLES=2):** `mem_busy`=1 for 3 cycles during the second stall cycle.
  - All enables are 0 for 3 cycles.
  - The stall then completes with 1 more stall cycle.
  - Final counts: `freeze_cnt`=3, `stall_cnt`=2.
- **Reset mid-stall:** assert `rst` in STALL.
  - While `rst` is high: `idex_bubble`=1, all writes 0.
  - After release: RUN with enables 1 and all counters 0.
- **Saturation and clear:** hold `mem_busy` for 65540 cycles.
  - `freeze_cnt`=16'hFFFF.
  - `clr_stats`=1 for one cycle while `mem_busy`=1 gives `freeze_cnt`=0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// ============================================================================
// hazard_ctrl : load-use / branch / memory-freeze hazard control for the
//               5-stage MIPS pipeline, with saturating event counters.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module hazard_ctrl #(
  parameter int STALL_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        idex_memread,
  input  logic [4:0]  idex_rt_addr,
  input  logic [4:0]  ifid_rs_addr,
  input  logic [4:0]  ifid_rt_addr,
  input  logic        ifid_uses_rt,
  input  logic        branch_taken,
  input  logic        mem_busy,
  input  logic        clr_stats,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        idex_write,
  output logic        idex_bubble,
  output logic        stalling,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt,
  output logic [15:0] freeze_cnt
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    STALL  = 2'd1,
    FREEZE = 2'd2
  } state_t;

  state_t state, state_nxt, ret, ret_nxt, eff_state;
  logic   cnt, cnt_nxt, ret_cnt, ret_cnt_nxt, eff_cnt;
  logic   hz;

  assign hz = idex_memread && (idex_rt_addr != 5'd0) &&
              ((idex_rt_addr == ifid_rs_addr) ||
               (ifid_uses_rt && (idex_rt_addr == ifid_rt_addr)));

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
  endfunction

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    ret_nxt     = ret;
    ret_cnt_nxt = ret_cnt;
    eff_state   = state;
    eff_cnt     = cnt;
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    ifid_flush  = 1'b0;
    idex_write  = 1'b0;
    idex_bubble = 1'b0;
    stalling    = 1'b0;

    if (rst) begin
      idex_bubble = 1'b1;
    end else if (mem_busy) begin
      state_nxt = FREEZE;
      // Only the first frozen cycle captures where to resume.
      if (state != FREEZE) begin
        ret_nxt     = state;
        ret_cnt_nxt = cnt;
      end
    end else begin
      if (state == FREEZE) begin
        eff_state = ret;
        eff_cnt   = ret_cnt;
      end
      state_nxt = eff_state;
      cnt_nxt   = eff_cnt;
      case (eff_state)
        STALL: begin
          idex_write  = 1'b1;
          idex_bubble = 1'b1;
          stalling    = 1'b1;
          cnt_nxt     = eff_cnt - 1'b1;
          if (eff_cnt == 1'b1) state_nxt = RUN;
        end
        default: begin
          if (hz) begin
            // A concurrent taken branch stays in ID and re-resolves later.
            idex_write  = 1'b1;
            idex_bubble = 1'b1;
            stalling    = 1'b1;
            if (STALL_CYCLES == 2) begin
              state_nxt = STALL;
              cnt_nxt   = 1'b1;
            end else begin
              state_nxt = RUN;
            end
          end else begin
            pc_write   = 1'b1;
            ifid_write = 1'b1;
            idex_write = 1'b1;
            ifid_flush = branch_taken;
            state_nxt  = RUN;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      cnt        <= 1'b0;
      ret        <= RUN;
      ret_cnt    <= 1'b0;
      stall_cnt  <= 16'd0;
      flush_cnt  <= 16'd0;
      freeze_cnt <= 16'd0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      ret     <= ret_nxt;
      ret_cnt <= ret_cnt_nxt;
      if (clr_stats) begin
        stall_cnt  <= 16'd0;
        flush_cnt  <= 16'd0;
        freeze_cnt <= 16'd0;
      end else begin
        stall_cnt  <= sat_inc(stall_cnt, stalling);
        flush_cnt  <= sat_inc(flush_cnt, ifid_flush);
        freeze_cnt <= sat_inc(freeze_cnt, mem_busy);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// tb_hazard_ctrl : directed scoreboard bench driving a 1-cycle and a 2-cycle
//                  stall instance of hazard_ctrl from one shared stimulus.
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst, idex_memread, ifid_uses_rt, branch_taken, mem_busy, clr_stats;
  logic [4:0]  idex_rt_addr, ifid_rs_addr, ifid_rt_addr;

  logic        pc1, ifw1, fl1, idw1, bub1, st1;
  logic        pc2, ifw2, fl2, idw2, bub2, st2;
  logic [15:0] sc1, fc1, zc1, sc2, fc2, zc2;

  always #5 clk = ~clk;

  hazard_ctrl #(.STALL_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .idex_memread(idex_memread), .idex_rt_addr(idex_rt_addr),
    .ifid_rs_addr(ifid_rs_addr), .ifid_rt_addr(ifid_rt_addr), .ifid_uses_rt(ifid_uses_rt),
    .branch_taken(branch_taken), .mem_busy(mem_busy), .clr_stats(clr_stats),
    .pc_write(pc1), .ifid_write(ifw1), .ifid_flush(fl1), .idex_write(idw1),
    .idex_bubble(bub1), .stalling(st1), .stall_cnt(sc1), .flush_cnt(fc1), .freeze_cnt(zc1)
  );

  hazard_ctrl #(.STALL_CYCLES(2)) dut2 (
    .clk(clk), .rst(rst), .idex_memread(idex_memread), .idex_rt_addr(idex_rt_addr),
    .ifid_rs_addr(ifid_rs_addr), .ifid_rt_addr(ifid_rt_addr), .ifid_uses_rt(ifid_uses_rt),
    .branch_taken(branch_taken), .mem_busy(mem_busy), .clr_stats(clr_stats),
    .pc_write(pc2), .ifid_write(ifw2), .ifid_flush(fl2), .idex_write(idw2),
    .idex_bubble(bub2), .stalling(st2), .stall_cnt(sc2), .flush_cnt(fc2), .freeze_cnt(zc2)
  );

  // Control vector order: {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, stalling}
  localparam logic [5:0] RUNO = 6'b110100;
  localparam logic [5:0] FLSH = 6'b111100;
  localparam logic [5:0] STLO = 6'b000111;
  localparam logic [5:0] FRZO = 6'b000000;
  localparam logic [5:0] RSTO = 6'b000010;

  typedef struct {
    string       tag;
    int          kind;
    logic [47:0] exp;
  } item_t;

  item_t q[$];
  int    total  = 0;
  int    passed = 0;

  function automatic logic [47:0] observe(input int kind);
    case (kind)
      0:       return {42'd0, pc1, ifw1, fl1, idw1, bub1, st1};
      1:       return {42'd0, pc2, ifw2, fl2, idw2, bub2, st2};
      2:       return {sc1, fc1, zc1};
      default: return {sc2, fc2, zc2};
    endcase
  endfunction

  task automatic drive(input logic mr, input logic [4:0] ex_rt, input logic [4:0] rs,
                       input logic [4:0] rt, input logic urt, input logic br,
                       input logic busy, input logic clr, input logic r);
    idex_memread = mr;  idex_rt_addr = ex_rt; ifid_rs_addr = rs; ifid_rt_addr = rt;
    ifid_uses_rt = urt; branch_taken = br;    mem_busy = busy;   clr_stats = clr;
    rst = r;
  endtask

  task automatic exp_ctl(input string tag, input logic [5:0] e1, input logic [5:0] e2);
    q.push_back('{{tag, "_s1"}, 0, {42'd0, e1}});
    q.push_back('{{tag, "_s2"}, 1, {42'd0, e2}});
  endtask

  task automatic exp_cnt(input string tag, input logic [15:0] s1, input logic [15:0] f1,
                         input logic [15:0] z1, input logic [15:0] s2,
                         input logic [15:0] f2, input logic [15:0] z2);
    q.push_back('{{tag, "_s1"}, 2, {s1, f1, z1}});
    q.push_back('{{tag, "_s2"}, 3, {s2, f2, z2}});
  endtask

  // Compare everything queued for this cycle mid-cycle, then advance one edge.
  task automatic tick();
    item_t       it;
    logic [47:0] obs;
    @(negedge clk);
    while (q.size() > 0) begin
      it  = q.pop_front();
      obs = observe(it.kind);
      total++;
      assert (obs === it.exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", it.tag, obs, it.exp);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    @(posedge clk); #1;

    exp_ctl("reset_ctl", RSTO, RSTO);                       tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    exp_ctl("run_idle", RUNO, RUNO);
    exp_cnt("reset_cnt", 0, 0, 0, 0, 0, 0);                 tick();

    // Load-use on Rs
    drive(1, 5, 5, 0, 0, 0, 0, 0, 0);
    exp_ctl("rs_hz", STLO, STLO);                           tick();
    drive(0, 0, 5, 0, 0, 0, 0, 0, 0);
    exp_ctl("rs_after", RUNO, STLO);                        tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    exp_ctl("rs_done", RUNO, RUNO);
    exp_cnt("rs_cnt", 1, 0, 0, 2, 0, 0);                    tick();

    // Load-use on Rt
    drive(1, 7, 0, 7, 1, 0, 0, 0, 0);
    exp_ctl("rt_hz", STLO, STLO);                           tick();
    drive(0, 0, 0, 7, 1, 0, 0, 0, 0);
    exp_ctl("rt_after", RUNO, STLO);                        tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    exp_ctl("rt_done", RUNO, RUNO);
    exp_cnt("rt_cnt", 2, 0, 0, 4, 0, 0);                    tick();
    drive(1, 7, 0, 7, 0, 0, 0, 0, 0);
    exp_ctl("rt_unused", RUNO, RUNO);                       tick();
    drive(1, 0, 0, 0, 1, 0, 0, 0, 0);
    exp_ctl("zero_reg", RUNO, RUNO);                        tick();

    // Hazard and taken branch in the same cycle
    drive(1, 3, 3, 0, 0, 1, 0, 0, 0);
    exp_ctl("hz_br", STLO, STLO);                           tick();
    drive(0, 0, 3, 0, 0, 1, 0, 0, 0);
    exp_ctl("br_held1", FLSH, STLO);                        tick();
    drive(0, 0, 3, 0, 0, 1, 0, 0, 0);
    exp_ctl("br_held2", FLSH, FLSH);                        tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    exp_ctl("br_done", RUNO, RUNO);
    exp_cnt("br_cnt", 3, 2, 0, 6, 1, 0);                    tick();

    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    exp_ctl("clr_ctl", RUNO, RUNO);                         tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    exp_cnt("clr_cnt", 0, 0, 0, 0, 0, 0);                   tick();

    // Freeze in the middle of the 2-cycle stall
    drive(1, 9, 9, 0, 0, 0, 0, 0, 0);
    exp_ctl("frz_hz", STLO, STLO);                          tick();
    drive(0, 0, 9, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      exp_ctl("frz_hold", FRZO, FRZO);                      tick();
    end
    drive(0, 0, 9, 0, 0, 0, 0, 0, 0);
    exp_ctl("frz_resume", RUNO, STLO);                      tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    exp_ctl("frz_done", RUNO, RUNO);
    exp_cnt("frz_cnt", 1, 0, 3, 2, 0, 3);                   tick();

    // Reset while stalling
    drive(1, 4, 4, 0, 0, 0, 0, 0, 0);
    exp_ctl("rst_hz", STLO, STLO);                          tick();
    drive(0, 0, 4, 0, 0, 0, 0, 0, 1);
    exp_ctl("rst_mid", RSTO, RSTO);                         tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    exp_ctl("rst_after", RUNO, RUNO);
    exp_cnt("rst_cnt", 0, 0, 0, 0, 0, 0);                   tick();

    // Freeze counter saturation and clear
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
    repeat (65540) tick();
    exp_ctl("sat_ctl", FRZO, FRZO);
    exp_cnt("sat_cnt", 0, 0, 16'hFFFF, 0, 0, 16'hFFFF);     tick();
    drive(0, 0, 0, 0, 0, 0, 1, 1, 0);
    exp_ctl("sat_clr", FRZO, FRZO);                         tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    exp_ctl("sat_resume", RUNO, RUNO);
    exp_cnt("sat_clr_cnt", 0, 0, 0, 0, 0, 0);               tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
